// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment message sequencer and its display controller.
package seg7_pkg;

    localparam int         NUM_DIGITS  = 8;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } seg7_state_e;

    // Byte k of a packed message is digit k (digit 0 in the least significant byte).
    function automatic logic [7:0] msg_byte(input logic [63:0] msg, input logic [2:0] idx);
        return msg[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/seg7_msg_sequencer_if.sv
// Requester/display bundle of the message sequencer; the DUT takes the slave modport.
interface seg7_msg_sequencer_if;
    import seg7_pkg::*;

    // req is a level: a requester holds it until it wants to stop asking. gnt is one-hot
    // from the arbitration edge through the DONE cycle; done pulses one cycle on the
    // granted bit. The message is captured at grant, so req/msg may change afterwards.
    logic [1:0]  req;
    logic [63:0] msg0;
    logic [63:0] msg1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        busy;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        clear;
    seg7_state_e state;

    modport master (
        output req, msg0, msg1,
        input  gnt, done, busy, char_out, char_valid, clear, state
    );

    modport slave (
        input  req, msg0, msg1,
        output gnt, done, busy, char_out, char_valid, clear, state
    );

endinterface

// File: rtl/seg7_rr_arbiter.sv
// Two-requester arbiter. SEG7_RR_ARB_EN selects round-robin; otherwise requester 0 has fixed priority.
module seg7_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

`ifdef SEG7_RR_ARB_EN
    // 1 means requester 1 was granted last, so requester 0 wins the first tie after reset.
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end
`else
    logic unused_ok;

    assign gnt_o     = {req_i[1] & ~req_i[0], req_i[0]};
    assign unused_ok = ^{clk, rst, advance_i};
`endif

endmodule

// File: rtl/seg7_msg_sequencer.sv
// Arbitrates two message requesters and streams the winner's 8 characters to the display.
// Build option: SEG7_RR_ARB_EN (round-robin arbitration, inside seg7_rr_arbiter).
module seg7_msg_sequencer
    import seg7_pkg::*;
#(
    parameter int HOLD_CYCLES = 250,
    parameter int NUM_DIGITS  = seg7_pkg::NUM_DIGITS
) (
    input  logic                  clk_500hz,
    input  logic                  rst,
    seg7_msg_sequencer_if.slave   bus
);

    seg7_state_e state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [63:0] shadow_q, shadow_d;
    logic [2:0]  char_cnt_q, char_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]  arb_gnt;
    logic        advance;

    seg7_rr_arbiter u_arb (
        .clk       (clk_500hz),
        .rst       (rst),
        .req_i     (bus.req),
        .advance_i (advance),
        .gnt_o     (arb_gnt)
    );

    always_ff @(posedge clk_500hz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            shadow_q   <= 64'h0;
            char_cnt_q <= 3'd0;
            hold_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            shadow_q   <= shadow_d;
            char_cnt_q <= char_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        shadow_d   = shadow_q;
        char_cnt_d = char_cnt_q;
        hold_cnt_d = hold_cnt_q;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    advance  = 1'b1;
                    gnt_d    = arb_gnt;
                    shadow_d = arb_gnt[1] ? bus.msg1 : bus.msg0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                char_cnt_d = 3'd0;
                state_d    = LOAD;
            end
            LOAD: begin
                char_cnt_d = char_cnt_q + 3'd1;
                if (char_cnt_q == 3'(NUM_DIGITS - 1)) begin
                    hold_cnt_d = 16'd0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 16'd1;
                if (hold_cnt_q == 16'(HOLD_CYCLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state, so reset clears them all at once.
    assign bus.gnt        = gnt_q;
    assign bus.done       = (state_q == DONE) ? gnt_q : 2'b00;
    assign bus.busy       = (state_q != IDLE);
    assign bus.clear      = (state_q == CLEAR);
    assign bus.char_valid = (state_q == LOAD);
    assign bus.char_out   = (state_q == LOAD) ? msg_byte(shadow_q, char_cnt_q) : 8'h00;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Randomised self-checking bench for seg7_msg_sequencer (HOLD_CYCLES = 4), with a timeline reference model.
module tb_seg7_msg_sequencer;
    import seg7_pkg::*;

    localparam int HC = 4;

    logic clk_500hz = 1'b0;
    logic rst       = 1'b1;

    seg7_msg_sequencer_if bus ();

    seg7_msg_sequencer #(.HOLD_CYCLES(HC)) dut (
        .clk_500hz (clk_500hz),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk_500hz = ~clk_500hz;

    int         total  = 0;
    int         bad    = 0;
    int         last_w = 1;
    logic [7:0] exp_q[$];

    // Reference arbitration: single requester wins; a tie goes to 0 (fixed) or to the one not granted last.
    function automatic int model_winner(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        if (r == 2'b11) begin
`ifdef SEG7_RR_ARB_EN
            return (last_w == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return -1;
    endfunction

    function automatic logic [1:0] rand_req();
        return 2'($urandom_range(1, 3));
    endfunction

    // Invariants sampled every cycle away from the active edge.
    always @(negedge clk_500hz) begin
        if (!rst) begin
            total++;
            if (bus.clear && bus.char_valid) begin
                bad++;
                $display("FAIL clear_and_valid: clear=%b char_valid=%b required not both", bus.clear, bus.char_valid);
            end
            total++;
            if (!$onehot0(bus.gnt)) begin
                bad++;
                $display("FAIL gnt_onehot: gnt=%b required one-hot or zero", bus.gnt);
            end
            total++;
            if (bus.busy !== (bus.state != IDLE)) begin
                bad++;
                $display("FAIL busy_state: busy=%b state=%0d", bus.busy, bus.state);
            end
            total++;
            if (!bus.char_valid && bus.char_out !== 8'h00) begin
                bad++;
                $display("FAIL char_out_idle: got %h required 00", bus.char_out);
            end
        end
    end

    // Call at a negedge with req/msg already driven; the next rising edge is the arbitration edge.
    task automatic run_message(input bit pulse, input bit mutate, output int w);
        logic [63:0] m;
        logic [1:0]  exp_g;
        logic [1:0]  exp_d;
        logic [7:0]  eb;
        w      = model_winner(bus.req);
        last_w = w;
        m      = (w == 1) ? bus.msg1 : bus.msg0;
        exp_g  = 2'(1 << w);
        for (int k = 0; k < 8; k++) exp_q.push_back(m[8*k +: 8]);
        for (int c = 1; c <= 10 + HC; c++) begin
            @(negedge clk_500hz);
            total++;
            if (bus.gnt !== exp_g) begin
                bad++;
                $display("FAIL gnt c%0d: got %b required %b", c, bus.gnt, exp_g);
            end
            total++;
            if (bus.clear !== (c == 1)) begin
                bad++;
                $display("FAIL clear c%0d: got %b required %b", c, bus.clear, (c == 1));
            end
            total++;
            if (bus.char_valid !== (c >= 2 && c <= 9)) begin
                bad++;
                $display("FAIL char_valid c%0d: got %b required %b", c, bus.char_valid, (c >= 2 && c <= 9));
            end
            if (bus.char_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL char_extra c%0d: got %h required none", c, bus.char_out);
                end else begin
                    eb = exp_q.pop_front();
                    if (bus.char_out !== eb) begin
                        bad++;
                        $display("FAIL char_out c%0d: got %h required %h", c, bus.char_out, eb);
                    end
                end
            end
            exp_d = (c == 10 + HC) ? exp_g : 2'b00;
            total++;
            if (bus.done !== exp_d) begin
                bad++;
                $display("FAIL done c%0d: got %b required %b", c, bus.done, exp_d);
            end
            total++;
            if (bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL busy c%0d: got %b required 1", c, bus.busy);
            end
            if (pulse && c == 1) bus.req = 2'b00;
            if (mutate && c == 3) begin
                bus.msg0 = {$urandom, $urandom};
                bus.msg1 = {$urandom, $urandom};
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL chars_missing: got %0d left required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_500hz);
            total++;
            if (bus.busy !== 1'b0 || bus.gnt !== 2'b00 || bus.done !== 2'b00 ||
                bus.clear !== 1'b0 || bus.char_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle: busy=%b gnt=%b done=%b clear=%b cv=%b required all 0",
                         bus.busy, bus.gnt, bus.done, bus.clear, bus.char_valid);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_500hz);
        rst     = 1'b1;
        bus.req = 2'b00;
        last_w  = 1;
        #1;
        total++;
        if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0 || bus.char_out !== 8'h00 ||
            bus.char_valid !== 1'b0 || bus.clear !== 1'b0 || bus.state !== IDLE) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b done=%b busy=%b char=%h cv=%b clr=%b state=%0d required 0",
                     bus.gnt, bus.done, bus.busy, bus.char_out, bus.char_valid, bus.clear, bus.state);
        end
        @(negedge clk_500hz);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req  = 2'b00;
        bus.msg0 = 64'h0;
        bus.msg1 = 64'h0;
        apply_reset();
        idle_cycles(2);
    endtask

    task automatic test_simultaneous();
        int w;
        apply_reset();
        bus.req  = 2'b11;
        bus.msg0 = {$urandom, $urandom};
        bus.msg1 = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) idle_cycles(1);
            run_message(1'b0, 1'b0, w);
        end
        bus.req = 2'b00;
        idle_cycles(2);
    endtask

    task automatic test_hello();
        logic [7:0]  hello [8] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h2D, 8'h31, 8'h32};
        logic [63:0] m;
        int          w;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = hello[k];
        bus.msg0 = m;
        bus.msg1 = {$urandom, $urandom};
        bus.req  = 2'b01;
        run_message(1'b0, 1'b0, w);
        bus.req = 2'b00;
        idle_cycles(2);
    endtask

    task automatic test_pulse_mutate();
        int w;
        bus.msg1 = {$urandom, $urandom};
        bus.req  = 2'b10;
        run_message(1'b1, 1'b1, w);
        idle_cycles(3);
    endtask

    task automatic test_reset_mid_load();
        logic [63:0] m;
        int          w;
        m        = {$urandom, $urandom};
        bus.msg0 = m;
        bus.req  = 2'b01;
        for (int c = 1; c <= 6; c++) @(negedge clk_500hz);
        total++;
        if (bus.char_valid !== 1'b1 || bus.char_out !== m[39:32]) begin
            bad++;
            $display("FAIL pre_reset_char4: cv=%b char=%h required 1 %h", bus.char_valid, bus.char_out, m[39:32]);
        end
        rst     = 1'b1;
        bus.req = 2'b00;
        last_w  = 1;
        #1;
        total++;
        if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0 || bus.char_out !== 8'h00 ||
            bus.char_valid !== 1'b0 || bus.clear !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: gnt=%b done=%b busy=%b char=%h cv=%b clr=%b required 0",
                     bus.gnt, bus.done, bus.busy, bus.char_out, bus.char_valid, bus.clear);
        end
        @(negedge clk_500hz);
        rst = 1'b0;
        idle_cycles(12);
        bus.msg0 = {$urandom, $urandom};
        bus.req  = 2'b01;
        run_message(1'b0, 1'b0, w);
        bus.req = 2'b00;
        idle_cycles(1);
    endtask

    task automatic test_random();
        int w;
        bit b2b;
        bus.req  = rand_req();
        bus.msg0 = {$urandom, $urandom};
        bus.msg1 = {$urandom, $urandom};
        for (int i = 0; i < 24; i++) begin
            run_message(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
            b2b = 1'($urandom_range(0, 1));
            if (b2b) begin
                bus.req  = rand_req();
                bus.msg0 = {$urandom, $urandom};
                bus.msg1 = {$urandom, $urandom};
                idle_cycles(1);
            end else begin
                bus.req = 2'b00;
                idle_cycles($urandom_range(1, 3));
                bus.req  = rand_req();
                bus.msg0 = {$urandom, $urandom};
                bus.msg1 = {$urandom, $urandom};
            end
        end
        bus.req = 2'b00;
        idle_cycles(2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simultaneous();
        test_hello();
        test_pulse_mutate();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
